// File: rtl/bus_bridge_burst_master.sv
// Burst-capable UART bus-bridge master.
// Queues UART command words {mode, len, data, addr} in a command FIFO and expands each
// command into len+1 single-beat bus transactions at incrementing (wrapping) addresses.
// Read data goes into a response FIFO that drains to UART TX. Each beat has a timeout.
//   clk, rst            clock, asynchronous active-high reset
//   rx_valid, rx_cmd    command word strobe and payload {mode, len, data, addr}
//   dwdata/daddr/dmode  beat write data, address and mode (1 = write) to master_port
//   dvalid              one-cycle beat request
//   dready, drdata      master_port idle/done handshake and read data
//   tx_data, tx_en      byte to UART TX and its one-cycle send strobe
//   tx_busy             UART TX busy
//   clr_status          clears the sticky overflow / timeout_err flags
//   busy, cmd_count     activity indication and command FIFO occupancy
//   overflow            sticky: a command word was dropped
//   timeout_err         sticky: a beat timed out
module bus_bridge_burst_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BB_ADDR_WIDTH  = 12,
  parameter int unsigned LEN_WIDTH      = 4,
  parameter int unsigned CMD_DEPTH      = 8,
  parameter int unsigned RSP_DEPTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 8'hEE
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           rx_valid,
  input  logic [1+LEN_WIDTH+DATA_WIDTH+BB_ADDR_WIDTH-1:0] rx_cmd,
  output logic [DATA_WIDTH-1:0]                          dwdata,
  output logic [BB_ADDR_WIDTH-1:0]                       daddr,
  output logic                                           dmode,
  output logic                                           dvalid,
  input  logic                                           dready,
  input  logic [DATA_WIDTH-1:0]                          drdata,
  output logic [DATA_WIDTH-1:0]                          tx_data,
  output logic                                           tx_en,
  input  logic                                           tx_busy,
  input  logic                                           clr_status,
  output logic                                           busy,
  output logic [$clog2(CMD_DEPTH):0]                     cmd_count,
  output logic                                           overflow,
  output logic                                           timeout_err
);

  localparam int unsigned CMD_W  = 1 + LEN_WIDTH + DATA_WIDTH + BB_ADDR_WIDTH;
  localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic [1:0] {TxIdle, TxGuard, TxWait} tx_state_e;

  state_e    state;
  tx_state_e tx_state;

  // Command FIFO
  logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wptr, cmd_rptr;
  logic              cmd_full, cmd_push, cmd_pop;
  logic [CMD_W-1:0]  head;

  assign cmd_full = (cmd_count == (CMD_AW + 1)'(CMD_DEPTH));
  assign cmd_push = rx_valid && !cmd_full;
  assign cmd_pop  = (state == StIdle) && (cmd_count != '0);
  assign head     = cmd_mem[cmd_rptr];

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= rx_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + CMD_AW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + CMD_AW'(1);
      if (cmd_push && !cmd_pop)      cmd_count <= cmd_count + (CMD_AW + 1)'(1);
      else if (!cmd_push && cmd_pop) cmd_count <= cmd_count - (CMD_AW + 1)'(1);
    end
  end

  // Response FIFO
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [RSP_AW-1:0]     rsp_wptr, rsp_rptr;
  logic [RSP_AW:0]       rsp_count;
  logic                  rsp_push, rsp_pop;
  logic [DATA_WIDTH-1:0] rsp_wdata;

  // Beat control
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 seen_low;
  logic [TMR_W-1:0]     tmr;
  logic                 tmr_last, beat_done, beat_timeout;

  // A read beat may only start while the response FIFO has room for its byte; only one
  // beat is ever outstanding, so one free entry is enough.
  assign dvalid       = (state == StIssue) && dready &&
                        (dmode || (rsp_count != (RSP_AW + 1)'(RSP_DEPTH)));
  assign tmr_last     = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign beat_done    = (state == StWait) && dready && seen_low;
  assign beat_timeout = (state == StWait) && !beat_done && tmr_last;
  assign rsp_push     = !dmode && (beat_done || beat_timeout);
  assign rsp_wdata    = beat_timeout ? ERR_DATA : drdata;
  assign rsp_pop      = (tx_state == TxIdle) && (rsp_count != '0) && !tx_busy;
  assign busy         = (state != StIdle) || (cmd_count != '0);

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= rsp_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wptr  <= '0;
      rsp_rptr  <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + RSP_AW'(1);
      if (rsp_pop)  rsp_rptr <= rsp_rptr + RSP_AW'(1);
      if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + (RSP_AW + 1)'(1);
      else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - (RSP_AW + 1)'(1);
    end
  end

  // Burst FSM. daddr doubles as the running beat address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      dmode      <= 1'b0;
      dwdata     <= '0;
      daddr      <= '0;
      beats_left <= '0;
      seen_low   <= 1'b0;
      tmr        <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_pop) begin
            dmode      <= head[CMD_W-1];
            beats_left <= head[CMD_W-2 -: LEN_WIDTH];
            dwdata     <= head[BB_ADDR_WIDTH +: DATA_WIDTH];
            daddr      <= head[BB_ADDR_WIDTH-1:0];
            state      <= StIssue;
          end
        end
        StIssue: begin
          if (dvalid) begin
            seen_low <= 1'b0;
            tmr      <= '0;
            state    <= StWait;
          end
        end
        StWait: begin
          if (!dready) seen_low <= 1'b1;
          if (beat_done) begin
            if (beats_left == '0) begin
              state <= StIdle;
            end else begin
              daddr      <= daddr + BB_ADDR_WIDTH'(1);
              beats_left <= beats_left - LEN_WIDTH'(1);
              state      <= StIssue;
            end
          end else if (tmr_last) begin
            state <= StIdle;  // abandon the rest of the burst
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // TX drain FSM; the guard cycle covers UART TX not yet reporting busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TxIdle;
      tx_en    <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_en <= 1'b0;
      unique case (tx_state)
        TxIdle: begin
          if (rsp_pop) begin
            tx_en    <= 1'b1;
            tx_data  <= rsp_mem[rsp_rptr];
            tx_state <= TxGuard;
          end
        end
        TxGuard: tx_state <= TxWait;
        TxWait:  if (!tx_busy) tx_state <= TxIdle;
        default: tx_state <= TxIdle;
      endcase
    end
  end

  // Sticky status: a set event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (rx_valid && cmd_full) overflow <= 1'b1;
      else if (clr_status)      overflow <= 1'b0;
      if (beat_timeout)         timeout_err <= 1'b1;
      else if (clr_status)      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_bridge_burst_master.sv
module tb_bus_bridge_burst_master;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int LW = 4;
  localparam int CD = 8;
  localparam int RD = 4;
  localparam int TO = 1024;
  localparam logic [7:0] ERR = 8'hEE;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [24:0]   rx_cmd;
  logic [7:0]    dwdata;
  logic [11:0]   daddr;
  logic          dmode;
  logic          dvalid;
  logic          dready;
  logic [7:0]    drdata;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_busy;
  logic          clr_status;
  logic          busy;
  logic [3:0]    cmd_count;
  logic          overflow;
  logic          timeout_err;

  bus_bridge_burst_master #(
    .DATA_WIDTH(DW), .BB_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CMD_DEPTH(CD),
    .RSP_DEPTH(RD), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_cmd(rx_cmd),
    .dwdata(dwdata), .daddr(daddr), .dmode(dmode), .dvalid(dvalid),
    .dready(dready), .drdata(drdata), .tx_data(tx_data), .tx_en(tx_en),
    .tx_busy(tx_busy), .clr_status(clr_status), .busy(busy), .cmd_count(cmd_count),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted command expands into its list of beats; every read beat
  // that the bus model completes contributes one byte to the expected TX stream.
  logic [20:0] exp_beat_q[$];   // {mode, data, addr}
  logic [7:0]  exp_tx_q[$];
  int          cyc = 0;
  int          n_beats = 0;
  int          n_tx = 0;
  int          last_fire_cyc = -100;
  logic [11:0] first_addr, last_addr;
  bit          force_low = 0;
  bit          tx_hold = 0;
  bit          stuck_release = 0;
  int          stuck_cd = 0;
  int          stuck_fire_cyc = 0;

  task automatic model_cmd(input bit m, input int nb, input logic [7:0] d, input logic [11:0] a);
    logic [11:0] x;
    x = a;
    for (int i = 0; i < nb; i++) begin
      exp_beat_q.push_back({m, d, x});
      x = x + 12'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit m, input logic [3:0] l, input logic [7:0] d,
                      input logic [11:0] a, input bit model);
    rx_cmd   = {m, l, d, a};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (model) model_cmd(m, int'(l) + 1, d, a);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_beat_q.size() != 0 || exp_tx_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget)
      check("drain_timeout", 32'(exp_beat_q.size() + exp_tx_q.size()) + 32'(busy), 0);
    repeat (8) tick();
  endtask

  // Bus/UART model plus monitor: samples on the falling edge, drives after the rising edge.
  initial begin : responder
    int          low_left;
    int          txb;
    bit          fired;
    bit          fire_mode;
    bit          tx_seen;
    logic [20:0] e;
    low_left = 0;
    txb      = 0;
    fire_mode = 1'b0;
    dready   = 1'b1;
    drdata   = 8'h00;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      fired   = 1'b0;
      tx_seen = 1'b0;
      if (!rst && dvalid) begin
        fired     = 1'b1;
        fire_mode = dmode;
        check("dvalid_spacing", 32'(cyc - last_fire_cyc >= 3), 1);
        last_fire_cyc = cyc;
        if (n_beats == 0) first_addr = daddr;
        last_addr = daddr;
        n_beats++;
        if (exp_beat_q.size() == 0) begin
          check("beat_extra", 32'(dvalid), 0);
        end else begin
          e = exp_beat_q.pop_front();
          check("beat", {11'd0, dmode, dwdata, daddr}, {11'd0, e});
        end
      end
      if (!rst && tx_en) begin
        tx_seen = 1'b1;
        n_tx++;
        if (exp_tx_q.size() == 0) check("tx_extra", 32'(tx_en), 0);
        else check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (rst) begin
        low_left = 0;
        txb      = 0;
        dready   = 1'b1;
        tx_busy  = tx_hold;
      end else begin
        if (fired) begin
          if (stuck_cd > 0) begin
            stuck_cd--;
            if (stuck_cd == 0) begin
              stuck_fire_cyc = cyc;
              if (!fire_mode) exp_tx_q.push_back(ERR);
              low_left = -1;  // never completes on its own
            end else begin
              low_left = $urandom_range(1, 3);
            end
          end else begin
            low_left = $urandom_range(1, 3);
          end
          dready = 1'b0;
        end else if (low_left < 0) begin
          if (stuck_release) begin
            low_left = 0;
            dready   = 1'b1;
          end
        end else if (low_left > 0) begin
          low_left--;
          if (low_left == 0) begin
            dready = 1'b1;
            drdata = 8'($urandom);
            if (!fire_mode) exp_tx_q.push_back(drdata);
          end
        end else begin
          dready = !force_low;
        end
        if (tx_hold) begin
          tx_busy = 1'b1;
        end else if (tx_seen) begin
          txb     = $urandom_range(0, 4);
          tx_busy = (txb > 0);
        end else if (txb > 0) begin
          txb--;
          tx_busy = (txb > 0);
        end else begin
          tx_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    bit          mode;
    logic [3:0]  len;
    logic [7:0]  data;
    logic [11:0] addr;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
    int          exp_beats;
    int          exp_tx;
  } vec_t;

  initial begin : main
    vec_t vecs[5];
    int   n;
    int   total;
    bit   m;
    logic [3:0] l;

    vecs[0] = '{1'b1, 4'd3,  8'h5A, 12'h0FE, 12'h0FE, 12'h101, 4,  0};
    vecs[1] = '{1'b0, 4'd1,  8'h00, 12'hFFF, 12'hFFF, 12'h000, 2,  2};
    vecs[2] = '{1'b1, 4'd0,  8'hC3, 12'h123, 12'h123, 12'h123, 1,  0};
    vecs[3] = '{1'b0, 4'd15, 8'h00, 12'hFF8, 12'hFF8, 12'h007, 16, 16};
    vecs[4] = '{1'b1, 4'd7,  8'hA5, 12'h7FC, 12'h7FC, 12'h803, 8,  0};

    rst = 1'b1; rx_valid = 1'b0; rx_cmd = '0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dvalid", 32'(dvalid), 0);
    check("rst_daddr", 32'(daddr), 0);
    check("rst_dwdata", 32'(dwdata), 0);
    check("rst_dmode", 32'(dmode), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_count", 32'(cmd_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();

    // Directed single-command vectors
    for (int i = 0; i < 5; i++) begin
      n_beats = 0;
      n_tx    = 0;
      send(vecs[i].mode, vecs[i].len, vecs[i].data, vecs[i].addr, 1'b1);
      wait_idle(3000);
      check("vec_first_addr", 32'(first_addr), 32'(vecs[i].exp_first));
      check("vec_last_addr", 32'(last_addr), 32'(vecs[i].exp_last));
      check("vec_beats", n_beats, vecs[i].exp_beats);
      check("vec_tx", n_tx, vecs[i].exp_tx);
    end

    // Overflow: first command is taken by the FSM and stalls, eight fill the FIFO, tenth drops
    force_low = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 4'd0, 8'(8'h40 + i), 12'(12'h200 + i), i < 9);
      tick();
    end
    @(negedge clk);
    check("ovf_cmd_count", 32'(cmd_count), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_busy", 32'(busy), 1);
    @(posedge clk); #1;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 0);
    @(posedge clk); #1;
    force_low = 1'b0;
    wait_idle(3000);

    // Timeout on the second beat of a three-beat read
    n_beats  = 0;
    stuck_cd = 2;
    send(1'b0, 4'd2, 8'h00, 12'h3A0, 1'b0);
    model_cmd(1'b0, 2, 8'h00, 12'h3A0);
    n = 0;
    while (!timeout_err && n < TO + 300) begin
      tick();
      n++;
    end
    check("timeout_flag", 32'(timeout_err), 1);
    check("timeout_latency", 32'(cyc - stuck_fire_cyc), TO);
    stuck_release = 1'b1;
    repeat (3) tick();
    stuck_release = 1'b0;
    wait_idle(3000);
    check("timeout_beats", n_beats, 2);
    check("timeout_busy", 32'(busy), 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("timeout_cleared", 32'(timeout_err), 0);
    @(posedge clk); #1;

    // Response FIFO back-pressure: TX stalled, only RSP_DEPTH read beats may start
    tx_hold = 1'b1;
    tick();
    n_beats = 0;
    n_tx    = 0;
    send(1'b0, 4'd15, 8'h00, 12'h550, 1'b1);
    repeat (150) tick();
    check("rsp_gate_beats", n_beats, RD);
    tx_hold = 1'b0;
    wait_idle(5000);
    check("rsp_gate_tx", n_tx, 16);

    // Reset in the middle of a read burst
    tx_hold = 1'b1;
    tick();
    n_beats = 0;
    send(1'b0, 4'd3, 8'h00, 12'h010, 1'b1);
    n = 0;
    while (n_beats < 2 && n < 200) begin
      tick();
      n++;
    end
    check("mid_rst_reached", n_beats, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", {26'd0, dvalid, dmode, tx_en, busy, overflow, timeout_err}, 0);
    check("mid_rst_data", {daddr, dwdata, tx_data, cmd_count}, 0);
    @(posedge clk); #1;
    repeat (3) tick();
    exp_beat_q.delete();
    exp_tx_q.delete();
    tx_hold = 1'b0;
    n_tx    = 0;
    rst     = 1'b0;
    repeat (60) tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_tx", n_tx, 0);
    check("post_rst_beats", n_beats, 2);

    // Randomised traffic against the reference model
    n_beats = 0;
    total   = 0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (cmd_count >= 4'd7 && n < 2000) begin
        tick();
        n++;
      end
      if (n >= 2000) check("rand_fifo_stall", 32'(cmd_count), 0);
      m = 1'($urandom_range(0, 1));
      l = 4'($urandom_range(0, 7));
      total += int'(l) + 1;
      send(m, l, 8'($urandom), 12'($urandom), 1'b1);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(30000);
    check("rand_beats", n_beats, total);
    check("rand_overflow", 32'(overflow), 0);
    check("rand_timeout", 32'(timeout_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
